sprite_pixel_mem: RTL and testbench
===================================

Name: sprite_pixel_mem

Overview:
Parametrised, simulation- and synthesis-capable pixel/palette memory for the sprite and background pipeline. It replaces fixed 8-bit-address test memories. Depth is arbitrary (not power-of-two bound) and the address width covers the full depth. An internal fill sequencer initialises every word after reset or on request. One registered read port with valid handshake; one write port for runtime sprite updates.

Parameters:
DATA_W, 8, pixel/colour word width
DEPTH, 401, number of words; any value >= 2
ADDR_W, $clog2(DEPTH), address width (derived, not overridden)
FILL_VALUE, 8'h00 (DATA_W wide), value written to every word by the fill sweep
OOB_VALUE, 8'h00 (DATA_W wide), data returned for out-of-range reads (transparent colour)

Ports:
Clk  in  1  system clock, rising edge
Reset_n  in  1  asynchronous, active-low reset
Clear  in  1  single-cycle request to restart the fill sweep
Busy  out  1  high while the fill sweep runs
Rd_req  in  1  read request, sampled on rising edge
Rd_addr  in  ADDR_W  read address
Rd_valid  out  1  read data valid (1-cycle pulse per accepted request)
Rd_data  out  DATA_W  read data
Rd_oob  out  1  qualifies Rd_data: request address was >= DEPTH
We  in  1  write enable
Wr_addr  in  ADDR_W  write address
Wr_data  in  DATA_W  write data
Wr_err  out  1  1-cycle pulse: write dropped (out of range or Busy)

Behaviour:
- Reset (Reset_n=0, async): FSM -> FILL, fill counter=0, Busy=1, Rd_valid=0, Rd_data=0, Rd_oob=0, Wr_err=0. The array is not reset.
- FILL state: each rising edge writes FILL_VALUE to mem[counter], then counter+1. On the edge that writes DEPTH-1: counter -> 0, FSM -> READY.
- FILL timing: Busy=1 for exactly DEPTH edges after Reset_n rises, and Busy=0 after edge DEPTH.
- READY state: Busy=0. Clear=1 -> FILL with counter=0. Busy=1 from the next cycle.
- Clear during FILL restarts the counter at 0 (the sweep extends).
- Reset mid-sweep restarts the sweep from 0.
- Reads (READY only), latency 1:
  - Rd_req on edge N -> Rd_valid=1 after edge N.
  - In range: Rd_data=mem[Rd_addr], Rd_oob=0.
  - Rd_addr >= DEPTH: Rd_data=OOB_VALUE, Rd_oob=1.
  - Back-to-back requests are accepted every cycle.
  - Rd_valid=0 in any cycle without an accepted request. Rd_data holds its last value.
  - Rd_req while Busy is ignored: no Rd_valid, no error.
- Writes (READY only): We on edge N updates mem[Wr_addr] at edge N.
  - Wr_addr >= DEPTH, or We while Busy: no array change; Wr_err=1 for the cycle after edge N.
- Read and write to the same address on the same edge: write-first. Rd_data returns Wr_data.
- Clear and We on the same edge in READY: the write is dropped with Wr_err, and the sweep starts.
- Clear and Rd_req on the same edge in READY: the read is served (Rd_valid next cycle) and the sweep starts.
- Address compare is unsigned on the full ADDR_W. No truncation of the address to 8 bits anywhere.

Decomposition:
- Shared package sprite_mem_pkg holds:
  - FSM enum mem_state_t {ST_FILL, ST_READY}
  - default colour constants (COLOR_TRANSPARENT, COLOR_BLACK)
  - function addr_w(depth)
- One sub-module sprite_mem_fill_ctrl contains the FSM, fill counter, Busy and fill write-port mux outputs.
- Top-level sprite_pixel_mem contains the array, write arbitration, bounds checks and the read pipeline register.

Test Plan (DEPTH=401, DATA_W=8):
1. Release Reset_n, count edges -> Busy=1 for 401 edges then 0; reading addrs 0, 200, 400 -> Rd_data=8'h00, Rd_oob=0, Rd_valid one cycle after each Rd_req.
2. Write 8'hd9 to addr 300, then read 300 -> 8'hd9. Read 400 -> 8'h00. Read 401 and 511 -> Rd_data=OOB_VALUE, Rd_oob=1, Rd_valid=1.
3. Write addr 401 -> Wr_err pulses 1 cycle, then reading 400 is unchanged. Same-edge write 8'he2 plus read of addr 5 -> Rd_data=8'he2.
4. Write 8'h49 to addr 3, then Clear -> Busy=1 for 401 cycles. Rd_req during Busy -> no Rd_valid. After Busy drops, read addr 3 -> 8'h00.
5. Pull Reset_n low at fill count 150 for 2 cycles (async, mid-cycle), then release -> outputs zero immediately and Busy=1 for a full 401 edges again.
6. Back-to-back Rd_req on addrs 0..9 over 10 consecutive cycles with prior writes of value=addr -> Rd_valid high 10 cycles and Rd_data 0..9 in order, each one cycle late.

Source files
------------

// File: rtl/sprite_mem_pkg.sv
// Shared types and helpers for the sprite/background pixel memory.
// Holds the fill FSM states, default colours and address-width derivation.
package sprite_mem_pkg;

  typedef enum logic {ST_FILL, ST_READY} mem_state_t;

  localparam logic [7:0] COLOR_TRANSPARENT = 8'h00;
  localparam logic [7:0] COLOR_BLACK       = 8'h00;

  // Never narrower than one bit, so a 2-word memory still has an address port.
  function automatic int addr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/sprite_mem_fill_ctrl.sv
// Fill sequencer: sweeps every word of the pixel memory after reset or a clear
// request, and reports busy while the sweep is in progress.
module sprite_mem_fill_ctrl
  import sprite_mem_pkg::*;
#(
  parameter int DEPTH  = 401,
  parameter int ADDR_W = addr_w(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  output logic              o_busy,
  output logic              o_fill_we,
  output logic [ADDR_W-1:0] o_fill_addr
);

  localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(DEPTH - 1);

  mem_state_t        r_state;
  mem_state_t        w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_nxt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_FILL;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // A clear during the sweep restarts it from word 0 rather than being ignored.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_busy      = (r_state == ST_FILL);
    o_fill_we   = (r_state == ST_FILL);
    o_fill_addr = r_cnt;
    case (r_state)
      ST_FILL: begin
        if (i_clear) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == LP_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_READY;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_READY: begin
        if (i_clear) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_FILL;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = ST_FILL;
      end
    endcase
  end

endmodule

// File: rtl/sprite_pixel_mem.sv
// Pixel/palette memory of arbitrary depth with a fill sequencer, one registered
// read port (valid-qualified, out-of-range flagged) and one runtime write port.
module sprite_pixel_mem
  import sprite_mem_pkg::*;
#(
  parameter int                DATA_W     = 8,
  parameter int                DEPTH      = 401,
  parameter logic [DATA_W-1:0] FILL_VALUE = '0,
  parameter logic [DATA_W-1:0] OOB_VALUE  = '0,
  localparam int               ADDR_W     = addr_w(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  output logic              o_busy,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_rd_valid,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_oob,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_err
);

  // One extra bit so the bound stays exact even when DEPTH is a power of two.
  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_busy;
  logic              w_fill_we;
  logic [ADDR_W-1:0] w_fill_addr;
  logic              w_rd_inrange;
  logic              w_wr_inrange;
  logic              w_wr_ok;
  logic              w_rd_acc;
  logic [DATA_W-1:0] w_rd_word;

  logic              r_rd_valid;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_oob;
  logic              r_wr_err;

  sprite_mem_fill_ctrl #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fill_ctrl (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_clear     (i_clear),
    .o_busy      (w_busy),
    .o_fill_we   (w_fill_we),
    .o_fill_addr (w_fill_addr)
  );

  assign w_rd_inrange = ({1'b0, i_rd_addr} < LP_DEPTH);
  assign w_wr_inrange = ({1'b0, i_wr_addr} < LP_DEPTH);
  // A clear on the same edge wins over a runtime write, since the sweep erases it anyway.
  assign w_wr_ok      = i_we && !w_busy && !i_clear && w_wr_inrange;
  assign w_rd_acc     = i_rd_req && !w_busy;

  always_ff @(posedge i_clk) begin
    if (w_fill_we) begin
      r_mem[w_fill_addr] <= FILL_VALUE;
    end else if (w_wr_ok) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Write-first: a same-edge write to the read address forwards the new data.
  always_comb begin
    w_rd_word = r_mem[i_rd_addr];
    if (!w_rd_inrange) begin
      w_rd_word = OOB_VALUE;
    end else if (w_wr_ok && (i_wr_addr == i_rd_addr)) begin
      w_rd_word = i_wr_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_rd_oob   <= 1'b0;
      r_wr_err   <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      r_wr_err   <= i_we && !w_wr_ok;
      if (w_rd_acc) begin
        r_rd_data <= w_rd_word;
        r_rd_oob  <= !w_rd_inrange;
      end
    end
  end

  assign o_busy     = w_busy;
  assign o_rd_valid = r_rd_valid;
  assign o_rd_data  = r_rd_data;
  assign o_rd_oob   = r_rd_oob;
  assign o_wr_err   = r_wr_err;

endmodule

// File: tb/tb_sprite_pixel_mem.sv
// Self-checking bench for sprite_pixel_mem (DEPTH=401, DATA_W=8): directed
// stimulus pushes expected reads into a scoreboard drained by a monitor.
module tb_sprite_pixel_mem;
  import sprite_mem_pkg::*;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 401;
  localparam int ADDR_W = addr_w(DEPTH);

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              oob;
    int                cyc;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clear;
  logic              busy;
  logic              rdReq;
  logic [ADDR_W-1:0] rdAddr;
  logic              rdValid;
  logic [DATA_W-1:0] rdData;
  logic              rdOob;
  logic              we;
  logic [ADDR_W-1:0] wrAddr;
  logic [DATA_W-1:0] wrData;
  logic              wrErr;

  int   testsRun    = 0;
  int   testsFailed = 0;
  int   cycleCount  = 0;
  int   n;
  exp_t sbQ[$];

  sprite_pixel_mem #(
    .DATA_W     (DATA_W),
    .DEPTH      (DEPTH),
    .FILL_VALUE (COLOR_BLACK),
    .OOB_VALUE  (COLOR_TRANSPARENT)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_clear    (clear),
    .o_busy     (busy),
    .i_rd_req   (rdReq),
    .i_rd_addr  (rdAddr),
    .o_rd_valid (rdValid),
    .o_rd_data  (rdData),
    .o_rd_oob   (rdOob),
    .i_we       (we),
    .i_wr_addr  (wrAddr),
    .i_wr_data  (wrData),
    .o_wr_err   (wrErr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  // Monitor: every valid read must match the oldest expectation, in the right cycle.
  always @(negedge clk) begin
    if (rdValid) begin
      testsRun++;
      if (sbQ.size() == 0) begin
        testsFailed++;
        $display("[TB] FAIL unexpectedValid: got data=%h oob=%0b, required no valid", rdData, rdOob);
      end else begin
        exp_t e;
        e = sbQ.pop_front();
        if (rdData !== e.data || rdOob !== e.oob || cycleCount != e.cyc) begin
          testsFailed++;
          $display("[TB] FAIL readData: got data=%h oob=%0b cycle=%0d, required data=%h oob=%0b cycle=%0d",
                   rdData, rdOob, cycleCount, e.data, e.oob, e.cyc);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushExp(input logic [DATA_W-1:0] data, input logic oob);
    exp_t e;
    e.data = data;
    e.oob  = oob;
    e.cyc  = cycleCount + 1;
    sbQ.push_back(e);
  endtask

  // applyStimulus drives one optional read and one optional write for a single edge.
  task automatic applyStimulus(input logic doRd, input logic [ADDR_W-1:0] ra,
                               input logic doWr, input logic [ADDR_W-1:0] wa,
                               input logic [DATA_W-1:0] wd);
    rdReq  = doRd;
    rdAddr = ra;
    we     = doWr;
    wrAddr = wa;
    wrData = wd;
    tick();
    rdReq = 1'b0;
    we    = 1'b0;
  endtask

  task automatic doRead(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic oob);
    pushExp(d, oob);
    applyStimulus(1'b1, a, 1'b0, '0, '0);
  endtask

  task automatic doWrite(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic expErr);
    applyStimulus(1'b0, '0, 1'b1, a, d);
    checkOutput("wrErr", 32'(wrErr), 32'(expErr));
  endtask

  task automatic countFill(input string name);
    n = 0;
    while (busy && n < 1000) begin
      tick();
      n++;
    end
    checkOutput(name, n, DEPTH);
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; rdReq = 1'b0; rdAddr = '0;
    we = 1'b0; wrAddr = '0; wrData = '0;
    tick();
    checkOutput("rstBusy", 32'(busy), 1);
    checkOutput("rstValid", 32'(rdValid), 0);
    checkOutput("rstData", 32'(rdData), 0);
    checkOutput("rstOob", 32'(rdOob), 0);
    checkOutput("rstWrErr", 32'(wrErr), 0);
    tick();
    rst_n = 1'b1;

    // 1: initial sweep length and filled contents
    countFill("fillEdges");
    doRead(9'd0, 8'h00, 1'b0);
    doRead(9'd200, 8'h00, 1'b0);
    doRead(9'd400, 8'h00, 1'b0);

    // 2: runtime write and out-of-range reads
    doWrite(9'd300, 8'hd9, 1'b0);
    doRead(9'd300, 8'hd9, 1'b0);
    doRead(9'd400, 8'h00, 1'b0);
    doRead(9'd401, COLOR_TRANSPARENT, 1'b1);
    doRead(9'd511, COLOR_TRANSPARENT, 1'b1);

    // 3: dropped write, then same-edge write-first read
    doWrite(9'd401, 8'h55, 1'b1);
    tick();
    checkOutput("wrErrPulse", 32'(wrErr), 0);
    doRead(9'd400, 8'h00, 1'b0);
    pushExp(8'he2, 1'b0);
    applyStimulus(1'b1, 9'd5, 1'b1, 9'd5, 8'he2);
    checkOutput("wrErrFwd", 32'(wrErr), 0);
    doRead(9'd5, 8'he2, 1'b0);

    // 4: clear with same-edge read (served) and write (dropped), reads ignored while busy
    doWrite(9'd3, 8'h49, 1'b0);
    clear = 1'b1;
    pushExp(8'h49, 1'b0);
    applyStimulus(1'b1, 9'd3, 1'b1, 9'd10, 8'h77);
    clear = 1'b0;
    checkOutput("clrWrErr", 32'(wrErr), 1);
    checkOutput("clrBusy", 32'(busy), 1);
    rdReq = 1'b1;
    countFill("clrFillEdges");
    rdReq = 1'b0;
    doRead(9'd3, 8'h00, 1'b0);
    doRead(9'd10, 8'h00, 1'b0);

    // 5: async reset in the middle of a sweep
    doWrite(9'd300, 8'hd9, 1'b0);
    doRead(9'd300, 8'hd9, 1'b0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (150) tick();
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("midRstBusy", 32'(busy), 1);
    checkOutput("midRstData", 32'(rdData), 0);
    checkOutput("midRstValid", 32'(rdValid), 0);
    tick();
    tick();
    rst_n = 1'b1;
    countFill("rstFillEdges");

    // 6: back-to-back reads of value=addr
    for (int i = 0; i < 10; i++) doWrite(ADDR_W'(i), DATA_W'(i), 1'b0);
    for (int i = 0; i < 10; i++) begin
      pushExp(DATA_W'(i), 1'b0);
      rdReq  = 1'b1;
      rdAddr = ADDR_W'(i);
      tick();
    end
    rdReq = 1'b0;
    repeat (3) tick();
    checkOutput("sbEmpty", sbQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
